// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
// The slave modport is the unit itself; the master modport is the core plus memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: maps byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW onto a
// word-wide memory, with read-modify-write for sub-word stores and fault detection.
module load_store_unit #(
  parameter int DEPTH = 200
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_resp_rdata;
  logic        r_resp_fault;

  logic        w_accept;
  logic        w_bad_funct3;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_fault;
  logic        w_is_sw;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [2:0]  funct3,
                                          input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Only the addressed byte/halfword lane of the old word is replaced.
  function automatic logic [31:0] merge(input logic [31:0] word,
                                        input logic [31:0] data,
                                        input logic [1:0]  size,
                                        input logic [1:0]  off);
    logic [31:0] m;
    m = word;
    case (size)
      2'b00: m[{off, 3'b000} +: 8] = data[7:0];
      2'b01: if (off[1]) m[31:16] = data[15:0];
             else        m[15:0]  = data[15:0];
      default: m = data;
    endcase
    return m;
  endfunction

  assign w_accept       = bus.req_valid && (r_state == IDLE);
  assign w_out_of_range = {2'b00, bus.req_addr[31:2]} >= 32'(DEPTH);
  assign w_misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign w_bad_funct3   = bus.req_we ? (bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11))
                                     : (bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
  assign w_fault        = w_out_of_range || w_misaligned || w_bad_funct3;
  assign w_is_sw        = bus.req_we && (bus.req_funct3[1:0] == 2'b10);

  assign w_load_data = extract(bus.mem_rdata, r_funct3, r_addr[1:0]);
  assign w_merged    = merge(bus.mem_rdata, r_wdata, r_funct3[1:0], r_addr[1:0]);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) begin
                 if (w_fault)      w_next = RESP;
                 else if (w_is_sw) w_next = WRITE;
                 else              w_next = READ;
               end
      READ:    w_next = r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_we     <= bus.req_we;
          r_funct3 <= bus.req_funct3;
          r_addr   <= bus.req_addr;
          r_wdata  <= bus.req_wdata;
          if (w_fault) begin
            r_resp_rdata <= 32'h0;
            r_resp_fault <= 1'b1;
          end else if (w_is_sw) begin
            r_mem_wdata <= bus.req_wdata;
          end
        end
        READ: if (r_we) begin
          r_mem_wdata <= w_merged;
        end else begin
          r_resp_rdata <= w_load_data;
          r_resp_fault <= 1'b0;
        end
        WRITE: begin
          r_resp_rdata <= 32'h0;
          r_resp_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_fault = r_resp_fault;
  // Reset in the WRITE cycle must suppress the falling-edge memory write.
  assign bus.mem_we     = (r_state == WRITE) && !reset;
  assign bus.mem_addr   = {2'b00, r_addr[31:2]};
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: falling-edge word memory model plus a
// scoreboard of expected responses, latencies and memory-write counts.
module tb_load_store_unit;
  localparam int DEPTH = 200;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          wr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  load_store_unit_if bus();

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  int          we_pulses = 0;
  logic        poke_en   = 1'b0;
  logic [7:0]  poke_addr = 8'h0;
  logic [31:0] poke_data = 32'h0;

  assign bus.mem_rdata = (bus.mem_addr < 32'(DEPTH)) ? mem[bus.mem_addr[7:0]] : 32'h0;

  always @(negedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      we_pulses <= we_pulses + 1;
    end
  end

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   pulses0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp_v);
    end
  endtask

  task automatic poke(input int addr, input logic [31:0] data);
    poke_addr = 8'(addr);
    poke_data = data;
    poke_en   = 1'b1;
    @(negedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Drives one request, records its expectation, returns 1 time unit after the accept edge.
  task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit hold, input string tag,
                      input logic [31:0] exp_rdata, input bit exp_fault,
                      input int exp_lat, input int exp_wr);
    int guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    sb.push_back('{tag, exp_rdata, exp_fault, exp_lat, exp_wr});
    pulses0 = we_pulses;
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    exp_t e;
    int   lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({e.tag, "_lat"},   32'(lat),            32'(e.lat));
    chk({e.tag, "_rdata"}, bus.resp_rdata,      e.rdata);
    chk({e.tag, "_fault"}, 32'(bus.resp_fault), 32'(e.fault));
    chk({e.tag, "_wr"},    32'(we_pulses - pulses0), 32'(e.wr));
    @(posedge clk); #1;
    chk({e.tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    reset = 1'b1;
    poke(0,   32'h0000_0000);
    poke(3,   32'h8899_AABB);
    poke(5,   32'h1122_3344);
    poke(7,   32'h0102_0304);
    poke(199, 32'hCAFE_F00D);
    @(posedge clk); #1;
    chk("rst_ready", 32'(bus.req_ready),  32'd1);
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata,      32'h0);
    chk("rst_fault", 32'(bus.resp_fault), 32'd0);
    chk("rst_we",    32'(bus.mem_we),     32'd0);
    chk("rst_addr",  bus.mem_addr,        32'h0);
    chk("rst_wdata", bus.mem_wdata,       32'h0);
    reset = 1'b0;

    // Loads from word 3 = 0x8899AABB
    send(0, 3'b000, 32'h0D, 32'h0, 0, "lb_0d",  32'hFFFF_FFAA, 0, 2, 0); wait_resp();
    send(0, 3'b100, 32'h0F, 32'h0, 0, "lbu_0f", 32'h0000_0088, 0, 2, 0); wait_resp();
    send(0, 3'b101, 32'h0E, 32'h0, 0, "lhu_0e", 32'h0000_8899, 0, 2, 0); wait_resp();
    send(0, 3'b001, 32'h0C, 32'h0, 0, "lh_0c",  32'hFFFF_AABB, 0, 2, 0); wait_resp();
    send(0, 3'b010, 32'h0C, 32'h0, 0, "lw_0c",  32'h8899_AABB, 0, 2, 0); wait_resp();
    send(0, 3'b010, 32'h31C, 32'h0, 0, "lw_last", 32'hCAFE_F00D, 0, 2, 0); wait_resp();

    // Sub-word stores into word 5
    send(1, 3'b000, 32'h16, 32'hFFFF_FF55, 0, "sb_16", 32'h0, 0, 3, 1); wait_resp();
    chk("w5_after_sb", mem[5], 32'h1155_3344);
    send(1, 3'b001, 32'h14, 32'h0000_BEEF, 0, "sh_14", 32'h0, 0, 3, 1); wait_resp();
    chk("w5_after_sh", mem[5], 32'h1155_BEEF);

    // Faults: no memory write, zero data, one-edge latency
    send(0, 3'b010, 32'h12,  32'h0, 0, "lw_mis",  32'h0, 1, 1, 0); wait_resp();
    send(1, 3'b001, 32'h03,  32'h1234, 0, "sh_mis", 32'h0, 1, 1, 0); wait_resp();
    chk("w0_after_shmis", mem[0], 32'h0);
    send(0, 3'b010, 32'h320, 32'h0, 0, "lw_oor", 32'h0, 1, 1, 0); wait_resp();
    send(0, 3'b011, 32'h0C,  32'h0, 0, "ld_f011", 32'h0, 1, 1, 0); wait_resp();
    send(1, 3'b100, 32'h14,  32'hFF, 0, "st_f100", 32'h0, 1, 1, 0); wait_resp();
    chk("w5_after_badst", mem[5], 32'h1155_BEEF);

    // Back-to-back with req_valid held high
    send(1, 3'b010, 32'h00, 32'hDEAD_BEEF, 1, "sw_00", 32'h0, 0, 2, 1);
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h00;
    chk("b2b_busy", 32'(bus.req_ready), 32'd0);
    wait_resp();
    chk("b2b_ready_again", 32'(bus.req_ready), 32'd1);
    chk("w0_after_sw", mem[0], 32'hDEAD_BEEF);
    send(0, 3'b010, 32'h00, 32'h0, 0, "lw_00", 32'hDEAD_BEEF, 0, 2, 0); wait_resp();

    // Reset asserted in the WRITE cycle of an SB
    send(1, 3'b000, 32'h1C, 32'h0000_00AA, 0, "sb_rst", 32'h0, 0, 3, 1);
    @(posedge clk); #1;
    chk("rstw_we_before", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstw_we_gated", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstw_valid", 32'(bus.resp_valid), 32'd0);
    chk("rstw_ready", 32'(bus.req_ready),  32'd1);
    chk("rstw_wr",    32'(we_pulses - pulses0), 32'd0);
    chk("rstw_w7",    mem[7], 32'h0102_0304);
    if (sb.size() != 0) void'(sb.pop_front());

    send(0, 3'b010, 32'h1C, 32'h0, 0, "lw_1c", 32'h0102_0304, 0, 2, 0); wait_resp();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the word-organised data memory; all core loads and stores go through it.
- Converts RV32I byte-addressed loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-indexed memory accesses.
- Extracts and extends load data, and performs read-modify-write for sub-word stores because the memory only writes whole words.
- Detects misaligned, out-of-range and illegal accesses and reports them as faults with no memory side effect.

Parameters:
DEPTH, 200, number of 32-bit words in data memory; legal word indices are 0..DEPTH-1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  core presents a memory request.
req_ready  output  1  unit can accept a request; high only in IDLE.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I funct3 selecting width and sign.
req_addr  input  32  byte address.
req_wdata  input  32  store data; low byte/half/word used.
resp_valid  output  1  one-cycle pulse; request completed.
resp_rdata  output  32  extended load data; 0 for stores and faults.
resp_fault  output  1  request rejected; qualified by resp_valid.
mem_we  output  1  memory write enable; memory writes on the falling clk edge.
mem_addr  output  32  word index, equal to the captured req_addr[31:2] zero-extended.
mem_wdata  output  32  full word to write.
mem_rdata  input  32  combinational read data for mem_addr.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0, mem_addr=0, mem_wdata=0.
- IDLE:
  - Accept when req_valid && req_ready. Capture we, funct3, addr, wdata.
  - Fault checks at accept time:
    - halfword with addr[0]=1;
    - word with addr[1:0]!=0;
    - addr[31:2] >= DEPTH;
    - load funct3 in {011,110,111};
    - store funct3 not in {000,001,010}.
  - Fault -> RESP with fault=1.
  - Otherwise: loads, SB and SH -> READ; SW -> WRITE with mem_wdata=wdata.
- READ:
  - mem_addr is stable; mem_rdata is registered at the rising edge.
  - Loads -> RESP with extracted data. Stores -> WRITE with the merged word.
- WRITE: mem_we=1 for exactly this cycle; mem_wdata holds the merged word -> RESP.
- RESP: resp_valid=1 for one cycle -> IDLE. Responses have no backpressure; the core must accept them.
- Latency, counted as rising edges from the accept edge to resp_valid high:
  - fault: 1
  - load: 2
  - SW: 2
  - SB/SH: 3
  - Throughput: one request per latency+1 cycles.
- Byte order is little-endian; byte k = bits [8k+7:8k] and k = addr[1:0].
  - Halfword select: addr[1]=0 -> bits [15:0], addr[1]=1 -> bits [31:16].
- Load extension:
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes through.
- Sub-word store merge: replace only the addressed byte or halfword of the read word; all other bits are unchanged.
- Fault: no mem_we pulse, resp_rdata=0, resp_fault=1. A store always returns resp_rdata=0.
- mem_we is gated by !reset. Reset asserted while in WRITE must produce no memory write in that cycle.
- Reset in any state returns to IDLE at the next edge and drops any pending response.
- resp_rdata and resp_fault are meaningful only while resp_valid=1, and hold their last value otherwise.
- req_valid while not ready is ignored; the core must hold the request until accepted.

Test Plan:
- Preload word 3 = 0x8899AABB; LB addr 0x0D -> resp_rdata 0xFFFFFFAA, fault 0, resp_valid 2 edges after accept.
- Same word: LBU 0x0F -> 0x00000088; LHU 0x0E -> 0x00008899; LH 0x0C -> 0xFFFFAABB; LW 0x0C -> 0x8899AABB.
- Word 5 = 0x11223344; SB addr 0x16 data 0xFFFFFF55 -> a single mem_we pulse, word 5 becomes 0x11553344, response 3 edges after accept. Then SH addr 0x14 data 0xBEEF -> word 5 = 0x1155BEEF.
- Faults:
  - LW 0x12 -> fault=1, no mem_we, resp_rdata 0, 1-edge latency.
  - SH 0x03 -> fault, word unchanged.
  - LW addr 4*DEPTH (0x320) -> fault.
  - funct3=011 load -> fault.
- Back-to-back: req_valid held high with SW 0x00 = 0xDEADBEEF then LW 0x00. Second request accepted only when req_ready returns to 1; read returns 0xDEADBEEF.
- Reset asserted during the WRITE cycle of SB -> no mem_we, target word unchanged, next cycle IDLE with resp_valid=0 and req_ready=1.
